uart_rx_word: RTL and testbench
===============================

Name: uart_rx_word

Overview:
- UART 8N1 receiver that collects four consecutive bytes from the serial line and packs them into one 32-bit word for the AES datapath.
- It is the receive-side counterpart of the 32-bit word transmitter and uses the same byte and bit order (LSB byte first, LSB bit first).
- It provides a one-cycle valid strobe per completed word, a framing-error strobe, and an inter-byte timeout that discards partial words.

Parameters:
- CLKS_PER_BIT, 2582, clock cycles per serial bit period; must be ≥ 4.
- TIMEOUT_CLKS, 25820 (10 bit times), idle cycles allowed between bytes of one word before the partial word is discarded.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- data_in  input  1  serial RX line; idles high
- data_out  output  32  assembled word; byte0 → [7:0], byte1 → [15:8], byte2 → [23:16], byte3 → [31:24]
- data_valid  output  1  one-cycle pulse; data_out is valid on this cycle and held until the next word completes
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low
- busy  output  1  high while a byte is being received or a partial word is pending

Behaviour:
- Reset: asynchronous assert, synchronous release inside the design. All of the following clear on reset:
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0
  - state = IDLE, byte_cnt = 0, shift register = 0
  - both synchronizer flops = 1
- Input synchronizer: 2-flop chain on data_in; all logic uses the synchronized signal rx_s.
- Bit timer: counter 0..CLKS_PER_BIT-1. Mid-bit point is CLKS_PER_BIT/2 (integer division).
- State machine:
  - IDLE
    - rx_s falling edge (previous 1, current 0) → START, timer = 0.
  - START
    - At the mid-bit point, sample rx_s.
    - rx_s = 1 → glitch: go to IDLE; byte_cnt unchanged.
    - rx_s = 0 → timer = 0, bit_idx = 0, go to DATA.
  - DATA
    - Each time the timer reaches CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first).
    - After bit_idx 7 is sampled, go to STOP.
  - STOP
    - At CLKS_PER_BIT-1, sample rx_s.
    - rx_s = 1: write the byte into lane byte_cnt.
      - If byte_cnt = 3: load all 32 bits into data_out, pulse data_valid, set byte_cnt = 0.
      - Otherwise: byte_cnt += 1.
    - rx_s = 0: pulse frame_err, discard the byte and any partial word, set byte_cnt = 0.
    - Either case → IDLE.
- Latency: data_valid rises exactly 1 cycle after the byte-3 stop-bit sample. That sample is about 9.5 bit times after the byte-3 start edge, plus 2 cycles of synchronizer delay.
- Assembly buffer is separate from data_out. data_out changes only on a completed word and never shows a partial word.
- Timeout:
  - An idle counter runs in IDLE while byte_cnt ≠ 0.
  - When it reaches TIMEOUT_CLKS: byte_cnt = 0 and the partial word is discarded. No strobe is raised.
  - The counter clears on any start edge.
- busy = (state ≠ IDLE) OR (byte_cnt ≠ 0).
- Simultaneous events:
  - A falling edge on the same cycle the timeout fires: the timeout wins first, so byte_cnt = 0, then the new byte is treated as byte0.
  - data_valid and frame_err are never high together.
- Back-to-back bytes: a start edge detected in the first cycle after STOP returns to IDLE must be accepted. No extra idle time is required.
- Reset mid-byte or mid-word: everything clears immediately. The first falling edge after reset release starts byte0.
- Widths: the timer needs ceil(log2(CLKS_PER_BIT)) bits and the timeout counter ceil(log2(TIMEOUT_CLKS+1)) bits. Neither counter may wrap.

Test Plan:
- Word reception: use CLKS_PER_BIT = 16 and send bytes 0x78, 0x56, 0x34, 0x12 back-to-back. Expect one data_valid pulse, data_out = 0x12345678, frame_err never asserted.
- Two words back-to-back: send 0xDEADBEEF then 0x00000001. Expect exactly two data_valid pulses; data_out holds 0xDEADBEEF until the second pulse, then reads 0x00000001.
- Start glitch: drive a low pulse of 4 cycles (CLKS_PER_BIT = 16), then send a full word 0xA5A5A5A5. Expect no byte counted from the glitch and data_out = 0xA5A5A5A5.
- Framing error: send byte 0x11, then byte 0x22 with a low stop bit, then 4 good bytes 0x44, 0x33, 0x22, 0x11. Expect a frame_err pulse and byte_cnt = 0 after the bad stop bit, then data_out = 0x11223344.
- Timeout: use TIMEOUT_CLKS = 200. Send 2 bytes, idle 250 cycles, then send a full word 0xCAFEF00D. Expect busy to drop at the timeout, no valid pulse for the stale bytes, and data_out = 0xCAFEF00D.
- Reset mid-byte: assert rst during bit 4 of byte 2. Expect all outputs 0 immediately. Then send the word 0x01020304; expect data_out = 0x01020304.

Source files
------------

// File: rtl/uart_rx_word.sv
// UART 8N1 receiver: gathers four bytes (LSB byte first, LSB bit first) into a
// 32-bit word, with framing-error strobe and inter-byte timeout.
module uart_rx_word #(
  parameter int CLKS_PER_BIT = 2582,
  parameter int TIMEOUT_CLKS = 25820
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] BIT_MID  = TW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0]    rst_pipe_q, rst_pipe_d;
  logic          sync1_q, sync1_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   asm_q, asm_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d, frame_err_q, frame_err_d;
  logic          fall;

  // Reset asserts asynchronously; its release is held off two clocks so the
  // whole block leaves reset on a clean edge.
  always_comb rst_pipe_d = {rst_pipe_q[0], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= rst_pipe_d;
  end

  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    sync1_d      = data_in;
    rx_s_d       = sync1_q;
    rx_prev_d    = rx_s_q;
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    idle_d       = idle_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Timeout is evaluated before the start edge so a coincident edge
        // begins a fresh word.
        if (byte_cnt_q != 2'd0) begin
          if (idle_q == TO_LIM) begin
            byte_cnt_d = 2'd0;
            asm_d      = '0;
            idle_d     = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end else begin
          idle_d = '0;
        end
        if (fall) begin
          state_d = S_START;
          timer_d = '0;
          idle_d  = '0;
        end
      end
      S_START: begin
        if (timer_q == BIT_MID) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            timer_d   = '0;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s_q;
          timer_d            = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            case (byte_cnt_q)
              2'd0: asm_d[7:0]   = shift_q;
              2'd1: asm_d[15:8]  = shift_q;
              2'd2: asm_d[23:16] = shift_q;
              default: begin
                data_out_d   = {shift_q, asm_q};
                data_valid_d = 1'b1;
                asm_d        = '0;
              end
            endcase
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            frame_err_d = 1'b1;
            byte_cnt_d  = 2'd0;
            asm_d       = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst_pipe_q[1]) begin
      sync1_d      = 1'b1;
      rx_s_d       = 1'b1;
      rx_prev_d    = 1'b1;
      state_d      = S_IDLE;
      timer_d      = '0;
      bit_idx_d    = 3'd0;
      shift_d      = '0;
      byte_cnt_d   = 2'd0;
      asm_d        = '0;
      idle_d       = '0;
      data_out_d   = '0;
      data_valid_d = 1'b0;
      frame_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= '0;
      byte_cnt_q   <= 2'd0;
      asm_q        <= '0;
      idle_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      idle_q       <= idle_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE) || (byte_cnt_q != 2'd0);

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed + random bench for uart_rx_word; expected words come from a
// byte-list model of the serial stream.
module tb_uart_rx_word;
  localparam int CPB = 16;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        rst, data_in;
  logic [31:0] data_out;
  logic        data_valid, frame_err, busy;

  always #5 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  int          checks = 0, errors = 0;
  logic [31:0] obs_q[$], exp_q[$];
  logic [7:0]  partial[$];
  logic [31:0] last_exp = 32'h0;
  int          ferr_obs = 0, ferr_exp = 0, both_hi = 0;

  always @(negedge clk) begin
    if (data_valid) obs_q.push_back(data_out);
    if (frame_err) ferr_obs++;
    if (data_valid && frame_err) both_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial frame driver; rst_bit >= 0 pulses reset halfway through that data bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap, input int rst_bit);
    data_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      data_in = b[i];
      if (i == rst_bit) begin
        idle(CPB / 2);
        rst = 1'b1;
        data_in = 1'b1;
        @(negedge clk);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_ferr", {31'b0, frame_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        idle(2);
        rst = 1'b0;
        partial.delete();
        last_exp = 32'h0;
        idle(CPB);
        chk("post_rst_data_out", data_out, 32'h0);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        return;
      end
      idle(CPB);
    end
    data_in = stop_ok;
    idle(CPB);
    data_in = 1'b1;
    if (stop_ok) begin
      partial.push_back(b);
      if (partial.size() == 4) begin
        last_exp = {partial[3], partial[2], partial[1], partial[0]};
        exp_q.push_back(last_exp);
        partial.delete();
      end
    end else begin
      ferr_exp++;
      partial.delete();
    end
    idle(gap);
    if (gap > TO) partial.delete();
    if (gap > 0) chk("busy_after_byte", {31'b0, busy}, {31'b0, partial.size() != 0});
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit rnd);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], 1'b1, rnd ? int'($urandom_range(0, 20)) : gap, -1);
  endtask

  task automatic verify(input string tag);
    logic [31:0] o, e;
    idle(40);
    chk({tag, "_nwords"}, obs_q.size(), exp_q.size());
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_word"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_ferr"}, ferr_obs, ferr_exp);
    chk({tag, "_data_out"}, data_out, last_exp);
  endtask

  initial begin
    rst = 1'b1;
    data_in = 1'b1;
    idle(3);
    chk("reset_data_out", data_out, 32'h0);
    chk("reset_valid", {31'b0, data_valid}, 32'h0);
    chk("reset_ferr", {31'b0, frame_err}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    idle(5);

    send_word(32'h12345678, 0, 1'b0);
    verify("word1");

    send_word(32'hDEADBEEF, 0, 1'b0);
    idle(4);
    chk("hold_first", data_out, 32'hDEADBEEF);
    send_word(32'h00000001, 0, 1'b0);
    verify("two_words");

    data_in = 1'b0;
    idle(4);
    data_in = 1'b1;
    idle(40);
    chk("glitch_busy", {31'b0, busy}, 32'h0);
    send_word(32'hA5A5A5A5, 0, 1'b0);
    verify("glitch");

    send_byte(8'h11, 1'b1, 2, -1);
    send_byte(8'h22, 1'b0, 2, -1);
    send_word(32'h11223344, 0, 1'b0);
    verify("frame");

    send_byte(8'h5A, 1'b1, 0, -1);
    send_byte(8'hC3, 1'b1, 250, -1);
    send_word(32'hCAFEF00D, 0, 1'b0);
    verify("timeout");

    send_word(32'h87654321, 0, 1'b0);
    send_byte(8'h99, 1'b1, 0, -1);
    send_byte(8'h88, 1'b1, 0, -1);
    send_byte(8'h77, 1'b1, 0, 4);
    send_word(32'h01020304, 0, 1'b0);
    verify("rst_mid");

    for (int n = 0; n < 6; n++) send_word($urandom, 0, 1'b1);
    verify("random");

    chk("valid_ferr_exclusive", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
